move_scheduler: RTL and testbench

//  Serialises decoded player moves (left/right/spin/soft-down/hard-drop) and the gravity tick into one

---
 rtl/move_scheduler_pkg.sv | 34 +++
 rtl/move_scheduler_gravity_timer.sv | 44 ++++
 rtl/move_scheduler.sv | 136 +++++++++++++
 tb/tb_move_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_scheduler_pkg.sv
// Shared opcodes, game-state code, FSM encoding and pending-flag layout for the move scheduler.
package move_scheduler_pkg;

  localparam logic [1:0] ST_DRO   = 2'd1;

  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_DOWN  = 3'd3;
  localparam logic [2:0] OP_SPIN  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_HISSUE, S_HWAIT, S_LOCK
  } fsm_e;

  typedef struct packed {
    logic spc;
    logic spn;
    logic l;
    logic r;
    logic d;
    logic g;
  } pend_t;

  // Fixed selection order; soft-down and gravity share one DOWN command.
  function automatic logic [2:0] pick_op(pend_t p);
    if (p.spc)           return OP_DOWN;
    else if (p.spn)      return OP_SPIN;
    else if (p.l)        return OP_LEFT;
    else if (p.r)        return OP_RIGHT;
    else if (p.d || p.g) return OP_DOWN;
    return 3'd0;
  endfunction

endpackage

// File: rtl/move_scheduler_gravity_timer.sv
// Gravity period generator: speed-dependent period, sampled whenever the counter sits at zero.
module gravity_timer
  import move_scheduler_pkg::*;
#(
  parameter int unsigned GRAV_CYCLES = 50_000_000,
  parameter int unsigned GRAV_STEP   = 3_000_000,
  parameter int unsigned GRAV_MIN    = 5_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [3:0] speed_i,
  output logic       tick_o
);

  localparam int unsigned PW = CNT_W + 4;
  localparam logic [PW-1:0] HEADROOM = PW'(GRAV_CYCLES - GRAV_MIN);

  logic [PW-1:0]    prod;
  logic [CNT_W-1:0] per_calc, lim_q, cnt_q;

  // Compare against the headroom first so the subtraction can never wrap.
  always_comb begin
    prod = PW'(speed_i) * PW'(GRAV_STEP);
    if (prod >= HEADROOM) per_calc = CNT_W'(GRAV_MIN);
    else                  per_calc = CNT_W'(PW'(GRAV_CYCLES) - prod);
  end

  assign tick_o = en_i && !clr_i && (cnt_q == lim_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      lim_q <= CNT_W'(GRAV_CYCLES - 1);
    end else begin
      if (cnt_q == '0) lim_q <= per_calc - CNT_W'(1);
      if (clr_i || tick_o) cnt_q <= '0;
      else if (en_i)       cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Serialises player moves and gravity into a single-outstanding command stream for the board unit.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int unsigned GRAV_CYCLES = 50_000_000,
  parameter int unsigned GRAV_STEP   = 3_000_000,
  parameter int unsigned GRAV_MIN    = 5_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] state_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       down_i,
  input  logic       spin_i,
  input  logic       space_i,
  input  logic [3:0] speed_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_op_o,
  input  logic       cmd_ready_i,
  input  logic       rsp_valid_i,
  input  logic       rsp_ok_i,
  output logic       lock_req_o,
  input  logic       lock_ack_i,
  output logic       busy_o
);

  fsm_e       st_q, st_d;
  pend_t      pend_q, pend_d, pend_set, pend_clr, pend_eff;
  logic       vld_q, vld_d;
  logic [2:0] op_q, op_d;
  logic       dro, hard, acc, tick, grav_en, grav_clr;

  assign dro      = (state_i == ST_DRO);
  assign hard     = (st_q == S_HISSUE) || (st_q == S_HWAIT);
  assign acc      = vld_q && cmd_ready_i;
  assign grav_en  = dro && !hard && (st_q != S_LOCK);
  assign grav_clr = !dro || ((st_q == S_LOCK) && lock_ack_i);

  gravity_timer #(
    .GRAV_CYCLES(GRAV_CYCLES), .GRAV_STEP(GRAV_STEP),
    .GRAV_MIN(GRAV_MIN), .CNT_W(CNT_W)
  ) u_grav (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(grav_en), .clr_i(grav_clr),
    .speed_i(speed_i), .tick_o(tick)
  );

  always_comb begin
    pend_set = '0;
    if (dro && !hard) pend_set = {space_i, spin_i, left_i, right_i, down_i, tick};
    // Same-cycle pulses are visible to selection so a pulse at t offers at t+1.
    pend_eff = pend_q | pend_set;
    pend_clr = '0;
    st_d     = st_q;
    vld_d    = vld_q;
    op_d     = op_q;
    if (acc) begin
      vld_d = 1'b0;
      case (op_q)
        OP_SPIN:  pend_clr.spn = 1'b1;
        OP_LEFT:  pend_clr.l   = 1'b1;
        OP_RIGHT: pend_clr.r   = 1'b1;
        OP_DOWN: begin
          pend_clr.d   = 1'b1;
          pend_clr.g   = 1'b1;
          pend_clr.spc = hard;
        end
        default: ;
      endcase
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;

    unique case (st_q)
      S_IDLE: begin
        if (!dro) begin
          pend_d = '0;
        end else if (pend_eff != '0) begin
          vld_d = 1'b1;
          op_d  = pick_op(pend_eff);
          st_d  = pend_eff.spc ? S_HISSUE : S_ISSUE;
        end
      end
      S_ISSUE:  if (acc) st_d = S_WAIT;
      S_HISSUE: if (acc) st_d = S_HWAIT;
      S_WAIT: begin
        if (rsp_valid_i) begin
          st_d = S_IDLE;
          if (!dro)                             pend_d = '0;
          else if (op_q == OP_DOWN && !rsp_ok_i) st_d   = S_LOCK;
        end
      end
      S_HWAIT: begin
        if (rsp_valid_i) begin
          if (!dro) begin
            pend_d = '0;
            st_d   = S_IDLE;
          end else if (rsp_ok_i) begin
            vld_d = 1'b1;
            op_d  = OP_DOWN;
            st_d  = S_HISSUE;
          end else begin
            st_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        if (lock_ack_i) begin
          pend_d = '0;
          st_d   = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= S_IDLE;
      pend_q <= '0;
      vld_q  <= 1'b0;
      op_q   <= 3'd0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      op_q   <= op_d;
    end
  end

  assign cmd_valid_o = vld_q;
  assign cmd_op_o    = op_q;
  assign lock_req_o  = (st_q == S_LOCK);
  assign busy_o      = (st_q != S_IDLE);

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: vector tables, directed corner sequences and a random run against a reference model.
`timescale 1ns/1ps
module tb_move_scheduler;
  import move_scheduler_pkg::*;

  localparam int GC = 20, GS = 4, GM = 6, CW = 5;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] state = 2'd0;
  logic left = 0, right = 0, down = 0, spin = 0, space = 0;
  logic [3:0] speed = 4'd0;
  logic cmd_valid, lock_req, busy;
  logic [2:0] cmd_op;
  logic cmd_ready = 0, rsp_valid = 0, rsp_ok = 0, lock_ack = 0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  move_scheduler #(.GRAV_CYCLES(GC), .GRAV_STEP(GS), .GRAV_MIN(GM), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .state_i(state), .left_i(left), .right_i(right),
    .down_i(down), .spin_i(spin), .space_i(space), .speed_i(speed),
    .cmd_valid_o(cmd_valid), .cmd_op_o(cmd_op), .cmd_ready_i(cmd_ready),
    .rsp_valid_i(rsp_valid), .rsp_ok_i(rsp_ok), .lock_req_o(lock_req),
    .lock_ack_i(lock_ack), .busy_o(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_FREE = 0, M_OFFER = 1, M_RESULT = 2, M_DOFFER = 3, M_DRESULT = 4, M_LOCKED = 5;
  // request index: 0 hard drop, 1 spin, 2 left, 3 right, 4 soft down, 5 gravity (priority order)
  int OPS [6] = '{int'(OP_DOWN), int'(OP_SPIN), int'(OP_LEFT), int'(OP_RIGHT), int'(OP_DOWN), int'(OP_DOWN)};
  bit m_pend [6] = '{0, 0, 0, 0, 0, 0};
  int m_mode = M_FREE;
  bit m_vld = 0;
  int m_op = 0;
  int m_gcnt = 0;
  int m_gper = GC;

  function automatic int period_of(input int spd);
    int p = GC - spd * GS;
    return (p < GM) ? GM : p;
  endfunction

  task automatic model_step();
    bit dro, drop, gen, gclr, tick, acc;
    bit req [6];
    bit eff [6];
    bit clr [6];
    int first;
    dro  = (state == ST_DRO);
    drop = (m_mode == M_DOFFER) || (m_mode == M_DRESULT);
    gen  = dro && !drop && (m_mode != M_LOCKED);
    gclr = !dro || (m_mode == M_LOCKED && lock_ack);
    tick = gen && !gclr && (m_gcnt == m_gper - 1);
    if (m_gcnt == 0) m_gper = period_of(int'(speed));
    if (gclr || tick) m_gcnt = 0;
    else if (gen)     m_gcnt++;

    req = '{space, spin, left, right, down, tick};
    for (int i = 0; i < 6; i++) begin
      if (!dro || drop) req[i] = 0;
      eff[i] = m_pend[i] | req[i];
      clr[i] = 0;
    end
    acc = m_vld && cmd_ready;
    if (acc) begin
      m_vld = 0;
      if (m_op == int'(OP_SPIN))  clr[1] = 1;
      if (m_op == int'(OP_LEFT))  clr[2] = 1;
      if (m_op == int'(OP_RIGHT)) clr[3] = 1;
      if (m_op == int'(OP_DOWN)) begin clr[4] = 1; clr[5] = 1; clr[0] = drop; end
    end
    for (int i = 0; i < 6; i++) m_pend[i] = (m_pend[i] & !clr[i]) | req[i];

    case (m_mode)
      M_FREE: begin
        if (!dro) m_pend = '{0, 0, 0, 0, 0, 0};
        else begin
          first = -1;
          for (int i = 5; i >= 0; i--) if (eff[i]) first = i;
          if (first >= 0) begin
            m_vld  = 1;
            m_op   = OPS[first];
            m_mode = (first == 0) ? M_DOFFER : M_OFFER;
          end
        end
      end
      M_OFFER:  if (acc) m_mode = M_RESULT;
      M_DOFFER: if (acc) m_mode = M_DRESULT;
      M_RESULT: if (rsp_valid) begin
        if (!dro) begin m_pend = '{0, 0, 0, 0, 0, 0}; m_mode = M_FREE; end
        else if (m_op == int'(OP_DOWN) && !rsp_ok) m_mode = M_LOCKED;
        else m_mode = M_FREE;
      end
      M_DRESULT: if (rsp_valid) begin
        if (!dro) begin m_pend = '{0, 0, 0, 0, 0, 0}; m_mode = M_FREE; end
        else if (rsp_ok) begin m_vld = 1; m_mode = M_DOFFER; end
        else m_mode = M_LOCKED;
      end
      M_LOCKED: if (lock_ack) begin m_pend = '{0, 0, 0, 0, 0, 0}; m_mode = M_FREE; end
      default: m_mode = M_FREE;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '{0, 0, 0, 0, 0, 0};
      m_mode = M_FREE; m_vld = 0; m_op = 0; m_gcnt = 0; m_gper = GC;
    end else begin
      model_step();
    end
  end

  // ---------------- board unit ----------------
  bit rdy_force = 1, rdy_val = 1, ok_rand = 0;
  int lat_fix = 0;
  bit ok_q [$];

  initial begin
    int cd = 0;
    bit a;
    forever begin
      @(negedge clk);
      a = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      rsp_valid = 0;
      if (!rst_n) cd = 0;
      else if (a) cd = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1;
          if (ok_q.size() > 0) rsp_ok = ok_q.pop_front();
          else                 rsp_ok = ok_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      cmd_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / continuous comparison ----------------
  int log_q [$];
  bit saw_lock = 0;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) log_q.push_back(int'(cmd_op));
    if (lock_req) saw_lock = 1;
    chk("model_valid", cmd_valid, m_vld);
    if (m_vld) chk("model_op", cmd_op, m_op);
    chk("model_lock", lock_req, m_mode == M_LOCKED);
    chk("model_busy", busy, m_mode != M_FREE);
  end

  // ---------------- vector tables ----------------
  typedef struct { bit [4:0] p; int op; } opvec_t;   // p = {space, spin, down, right, left}
  typedef struct { int spd; int per; } gvec_t;
  opvec_t ov [7] = '{
    '{5'b00001, 1}, '{5'b00010, 2}, '{5'b00100, 3}, '{5'b01000, 4},
    '{5'b00011, 1}, '{5'b00110, 2}, '{5'b01001, 4}
  };
  gvec_t gv [6] = '{'{0, 20}, '{1, 16}, '{3, 8}, '{4, 6}, '{5, 6}, '{15, 6}};

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    {space, spin, down, right, left} = 5'b0;
  endtask

  task automatic go_idle();
    state = 2'd0;
    clr_pulses();
    for (int i = 0; i < 60 && busy; i++) begin lock_ack = lock_req; cyc(1); end
    lock_ack = 0;
    chk("drain_busy", busy, 0);
    cyc(2);
  endtask

  initial begin
    int n;
    int downs;
    #1 rst_n = 0;
    #1;
    chk("rst_valid", cmd_valid, 0); chk("rst_op", cmd_op, 0);
    chk("rst_lock", lock_req, 0);   chk("rst_busy", busy, 0);
    cyc(2); rst_n = 1; cyc(2);

    // single-command selection and t+1 latency
    foreach (ov[k]) begin
      state = ST_DRO;
      {space, spin, down, right, left} = ov[k].p;
      @(negedge clk); chk("vec_lat0", cmd_valid, 0);
      cyc(1); clr_pulses();
      @(negedge clk); chk("vec_valid", cmd_valid, 1); chk("vec_op", cmd_op, ov[k].op);
      go_idle();
    end

    // gravity period: first and second tick after entering play
    lat_fix = 1;
    foreach (gv[k]) begin
      speed = 4'(gv[k].spd); cyc(1);
      state = ST_DRO; n = 0;
      while (!cmd_valid && n < 60) begin cyc(1); n++; end
      chk("grav_first", n, gv[k].per);
      while (cmd_valid && n < 100) begin cyc(1); n++; end
      while (!cmd_valid && n < 100) begin cyc(1); n++; end
      chk("grav_second", n, 2 * gv[k].per);
      go_idle();
    end
    lat_fix = 0; speed = 0;

    // left+spin together: spin first, then left
    log_q.delete();
    state = ST_DRO; left = 1; spin = 1; cyc(1); clr_pulses();
    cyc(12);
    chk("pair_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("pair_first", log_q[0], int'(OP_SPIN)); chk("pair_second", log_q[1], int'(OP_LEFT));
    end
    go_idle();

    // hard drop: three free steps then blocked
    log_q.delete(); ok_q = '{1, 1, 1, 0};
    state = ST_DRO; space = 1; cyc(1); space = 0;
    for (n = 0; n < 80 && !lock_req; n++) cyc(1);
    chk("hd_lock", lock_req, 1);
    downs = 0;
    foreach (log_q[i]) if (log_q[i] == int'(OP_DOWN)) downs++;
    chk("hd_cmds", log_q.size(), 4); chk("hd_downs", downs, 4);
    repeat (5) begin cyc(1); chk("lock_hold", lock_req, 1); end
    lock_ack = 1; cyc(1); lock_ack = 0;
    chk("lock_clear", lock_req, 0); chk("lock_idle", busy, 0);
    go_idle();

    // stalled offer stays stable; later pulse stays pending
    log_q.delete(); rdy_val = 0;
    state = ST_DRO; down = 1; cyc(1); down = 0;
    for (int i = 0; i < 10; i++) begin
      right = (i == 3);
      @(negedge clk); chk("stall_valid", cmd_valid, 1); chk("stall_op", cmd_op, int'(OP_DOWN));
      cyc(1);
    end
    right = 0; rdy_val = 1;
    for (n = 0; n < 30 && log_q.size() < 2; n++) cyc(1);
    chk("stall_count", log_q.size() >= 2, 1);
    if (log_q.size() >= 2) begin
      chk("stall_first", log_q[0], int'(OP_DOWN)); chk("stall_second", log_q[1], int'(OP_RIGHT));
    end
    go_idle();

    // leave play while awaiting a blocked DOWN result
    lat_fix = 3; saw_lock = 0; ok_q = '{0};
    state = ST_DRO; down = 1; cyc(1); down = 0;
    for (n = 0; n < 10 && cmd_valid; n++) cyc(1);
    right = 1; cyc(1); right = 0; state = 2'd0;
    for (n = 0; n < 20 && busy; n++) cyc(1);
    chk("exit_idle", busy, 0); chk("exit_nolock", saw_lock, 0);
    cyc(2); lat_fix = 0;
    state = ST_DRO; n = 0;
    while (!cmd_valid && n < 40) begin cyc(1); n++; end
    chk("exit_grav_restart", n, GC);
    chk("exit_op_gravity", cmd_op, int'(OP_DOWN));
    go_idle();

    // reset while a command is offered
    rdy_val = 0; state = ST_DRO; left = 1; cyc(1); left = 0; cyc(1);
    chk("rst_mid_valid", cmd_valid, 1);
    #3 rst_n = 0; #1;
    chk("rstm_valid", cmd_valid, 0); chk("rstm_op", cmd_op, 0);
    chk("rstm_lock", lock_req, 0);   chk("rstm_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1; rdy_val = 1;
    repeat (10) begin @(negedge clk); chk("rst_quiet", cmd_valid, 0); end
    go_idle();

    // randomized traffic against the model
    rdy_force = 0; ok_rand = 1; state = ST_DRO;
    for (int c = 0; c < 2500; c++) begin
      left  = ($urandom_range(0, 19) == 0);
      right = ($urandom_range(0, 19) == 0);
      down  = ($urandom_range(0, 24) == 0);
      spin  = ($urandom_range(0, 24) == 0);
      space = ($urandom_range(0, 69) == 0);
      if ($urandom_range(0, 79) == 0) state = (state == ST_DRO) ? 2'($urandom_range(0, 3)) : ST_DRO;
      if ($urandom_range(0, 49) == 0) speed = 4'($urandom_range(0, 15));
      lock_ack = (lock_req && $urandom_range(0, 3) == 0) || ($urandom_range(0, 40) == 0);
      cyc(1);
    end
    lock_ack = 0; rdy_force = 1; rdy_val = 1; ok_rand = 0;
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
